// File: rtl/bcp_pkg.sv
// Shared types and default sizing for the BCP propagation controller slice.
package bcp_pkg;

    localparam int BCP_MAX_VARIABLE_ID       = 4;
    localparam int BCP_VARIABLE_ENCODING_LEN = $clog2(BCP_MAX_VARIABLE_ID + 1);
    localparam int BCP_MAX_CLAUSE            = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BCAST  = 2'b01,
        SCAN   = 2'b10,
        RESULT = 2'b11
    } bcp_state_e;

    typedef enum logic [1:0] {
        OK             = 2'b00,
        CONFLICT       = 2'b01,
        REJECTED       = 2'b10,
        PROTOCOL_ERROR = 2'b11
    } bcp_status_e;

endpackage

// File: rtl/bcp_propagation_controller_if.sv
// Host-side decision/result handshake of the propagation controller.
// Signal names are seen from the controller (i = into it, o = out of it).
interface bcp_propagation_controller_if
    import bcp_pkg::*;
#(
    parameter int VARIABLE_ENCODING_LEN = BCP_VARIABLE_ENCODING_LEN
) ();

    logic                             decision_valid_i;
    logic                             decision_ready_o;
    logic [VARIABLE_ENCODING_LEN-1:0] decision_variable_id_i;
    logic                             decision_assignment_i;
    logic                             result_valid_o;
    logic                             result_ready_i;
    logic [1:0]                       result_status_o;
    logic [VARIABLE_ENCODING_LEN-1:0] result_implication_count_o;

    // Solver host: issues decisions, consumes results.
    modport master (
        output decision_valid_i, decision_variable_id_i, decision_assignment_i, result_ready_i,
        input  decision_ready_o, result_valid_o, result_status_o, result_implication_count_o
    );

    // Propagation controller: accepts decisions, produces results.
    modport slave (
        input  decision_valid_i, decision_variable_id_i, decision_assignment_i, result_ready_i,
        output decision_ready_o, result_valid_o, result_status_o, result_implication_count_o
    );

endinterface

// File: rtl/bcp_unit_select.sv
// Combinational selection of the lowest-index unit clause plus a
// conflict summary over the whole clause array.
module bcp_unit_select
    import bcp_pkg::*;
#(
    parameter int MAX_CLAUSE            = BCP_MAX_CLAUSE,
    parameter int VARIABLE_ENCODING_LEN = BCP_VARIABLE_ENCODING_LEN
) (
    input  logic [MAX_CLAUSE-1:0]                       clause_unit_i,
    input  logic [MAX_CLAUSE-1:0]                       clause_conflict_i,
    input  logic [MAX_CLAUSE*VARIABLE_ENCODING_LEN-1:0] implication_variable_id_i,
    input  logic [MAX_CLAUSE-1:0]                       implication_assignment_i,
    output logic                                        unit_found_o,
    output logic [VARIABLE_ENCODING_LEN-1:0]            unit_variable_id_o,
    output logic                                        unit_assignment_o,
    output logic                                        any_conflict_o
);

    assign unit_found_o   = |clause_unit_i;
    assign any_conflict_o = |clause_conflict_i;

    // Priority encode: walk from the top so the lowest unit index is written last and wins.
    always_comb begin
        unit_variable_id_o = '0;
        unit_assignment_o  = 1'b0;
        for (int k = MAX_CLAUSE - 1; k >= 0; k--) begin
            unit_variable_id_o = clause_unit_i[k]
                ? implication_variable_id_i[k*VARIABLE_ENCODING_LEN +: VARIABLE_ENCODING_LEN]
                : unit_variable_id_o;
            unit_assignment_o  = clause_unit_i[k] ? implication_assignment_i[k] : unit_assignment_o;
        end
    end

endmodule

// File: rtl/bcp_propagation_controller.sv
// Broadcast side of the BCP accelerator: takes one host decision, broadcasts
// it and every resulting implication to the clause array, keeps the global
// assignment bitmap, and reports OK / CONFLICT / REJECTED / PROTOCOL_ERROR.
module bcp_propagation_controller
    import bcp_pkg::*;
#(
    parameter int MAX_VARIABLE_ID       = BCP_MAX_VARIABLE_ID,
    parameter int VARIABLE_ENCODING_LEN = $clog2(MAX_VARIABLE_ID + 1),
    parameter int MAX_CLAUSE            = BCP_MAX_CLAUSE
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    bcp_propagation_controller_if.slave                 host_if,
    output logic                                        update_assignment_o,
    output logic [VARIABLE_ENCODING_LEN-1:0]            decision_variable_id_o,
    output logic                                        decision_assignment_o,
    input  logic [MAX_CLAUSE-1:0]                       clause_unit_i,
    input  logic [MAX_CLAUSE-1:0]                       clause_conflict_i,
    input  logic [MAX_CLAUSE*VARIABLE_ENCODING_LEN-1:0] implication_variable_id_i,
    input  logic [MAX_CLAUSE-1:0]                       implication_assignment_i,
    output logic [MAX_VARIABLE_ID:0]                    assigned_o,
    output logic [MAX_VARIABLE_ID:0]                    assignment_value_o
);

    localparam int                             ENC    = VARIABLE_ENCODING_LEN;
    localparam logic [ENC-1:0]                 MAX_ID = ENC'(MAX_VARIABLE_ID);
    localparam logic [ENC-1:0]                 CNT_MAX = '1;

    bcp_state_e             state_q, state_d;
    bcp_status_e            status_q, status_d;
    logic [ENC-1:0]         count_q, count_d;
    logic [MAX_VARIABLE_ID:0] assigned_q, assigned_d;
    logic [MAX_VARIABLE_ID:0] value_q, value_d;
    logic                   ready_q, ready_d;
    logic                   rvalid_q, rvalid_d;
    logic                   strobe_q, strobe_d;
    logic [ENC-1:0]         bid_q, bid_d;
    logic                   bval_q, bval_d;

    logic                   load_s;
    logic [ENC-1:0]         load_id_s;
    logic                   load_val_s;
    logic                   unit_found_s;
    logic [ENC-1:0]         unit_id_s;
    logic                   unit_val_s;
    logic                   any_conflict_s;

    // An id is usable only if it names a real variable that is still free.
    function automatic logic id_usable(input logic [ENC-1:0] id, input logic [MAX_VARIABLE_ID:0] bitmap);
        if ((id == '0) || (id > MAX_ID)) begin
            return 1'b0;
        end else begin
            return ~bitmap[id];
        end
    endfunction

    bcp_unit_select #(
        .MAX_CLAUSE            (MAX_CLAUSE),
        .VARIABLE_ENCODING_LEN (ENC)
    ) u_unit_select (
        .clause_unit_i             (clause_unit_i),
        .clause_conflict_i         (clause_conflict_i),
        .implication_variable_id_i (implication_variable_id_i),
        .implication_assignment_i  (implication_assignment_i),
        .unit_found_o              (unit_found_s),
        .unit_variable_id_o        (unit_id_s),
        .unit_assignment_o         (unit_val_s),
        .any_conflict_o            (any_conflict_s)
    );

    // State and every output register; reset clears all of them, bitmap included.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            status_q   <= OK;
            count_q    <= '0;
            assigned_q <= '0;
            value_q    <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            strobe_q   <= 1'b0;
            bid_q      <= '0;
            bval_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            count_q    <= count_d;
            assigned_q <= assigned_d;
            value_q    <= value_d;
            ready_q    <= ready_d;
            rvalid_q   <= rvalid_d;
            strobe_q   <= strobe_d;
            bid_q      <= bid_d;
            bval_q     <= bval_d;
        end
    end

    // Next state, result bookkeeping and the broadcast that the next cycle will carry.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        count_d    = count_q;
        load_s     = 1'b0;
        load_id_s  = '0;
        load_val_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (host_if.decision_valid_i && ready_q) begin
                    count_d = '0;
                    if (id_usable(host_if.decision_variable_id_i, assigned_q)) begin
                        state_d    = BCAST;
                        load_s     = 1'b1;
                        load_id_s  = host_if.decision_variable_id_i;
                        load_val_s = host_if.decision_assignment_i;
                    end else begin
                        state_d  = RESULT;
                        status_d = REJECTED;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BCAST: begin
                state_d = SCAN;
            end
            SCAN: begin
                if (any_conflict_s) begin
                    state_d  = RESULT;
                    status_d = CONFLICT;
                end else if (unit_found_s) begin
                    if (id_usable(unit_id_s, assigned_q)) begin
                        state_d    = BCAST;
                        load_s     = 1'b1;
                        load_id_s  = unit_id_s;
                        load_val_s = unit_val_s;
                        count_d    = (count_q == CNT_MAX) ? count_q : count_q + ENC'(1);
                    end else begin
                        state_d  = RESULT;
                        status_d = PROTOCOL_ERROR;
                    end
                end else begin
                    state_d  = RESULT;
                    status_d = OK;
                end
            end
            RESULT: begin
                if (host_if.result_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bitmap is written together with the broadcast so it is visible during the strobe.
    always_comb begin
        assigned_d = assigned_q;
        value_d    = value_q;
        if (load_s) begin
            assigned_d[load_id_s] = 1'b1;
            value_d[load_id_s]    = load_val_s;
        end else begin
            assigned_d = assigned_q;
            value_d    = value_q;
        end
        ready_d  = (state_d == IDLE);
        rvalid_d = (state_d == RESULT);
        strobe_d = load_s;
        bid_d    = load_s ? load_id_s : '0;
        bval_d   = load_s & load_val_s;
    end

    assign host_if.decision_ready_o           = ready_q;
    assign host_if.result_valid_o             = rvalid_q;
    assign host_if.result_status_o            = status_q;
    assign host_if.result_implication_count_o = count_q;
    assign update_assignment_o                = strobe_q;
    assign decision_variable_id_o             = bid_q;
    assign decision_assignment_o              = bval_q;
    assign assigned_o                         = assigned_q;
    assign assignment_value_o                 = value_q;

endmodule

// File: tb/tb_bcp_propagation_controller.sv
// Bench for bcp_propagation_controller: a behavioural clause array drives the
// clause side, and a propagation model computes the expected broadcasts,
// status, count, latency and bitmap for each decision.
module tb_bcp_propagation_controller;

    localparam int NC   = 16;
    localparam int ENC  = 3;
    localparam int MAXV = 4;
    localparam int ST_OK = 0, ST_CONF = 1, ST_REJ = 2, ST_PROTO = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcp_propagation_controller_if #(.VARIABLE_ENCODING_LEN(ENC)) host_if ();

    logic              upd;
    logic [ENC-1:0]    bid;
    logic              bval;
    logic [NC-1:0]     cu, cc, ia;
    logic [NC*ENC-1:0] iid;
    logic [MAXV:0]     asg, aval;

    bcp_propagation_controller #(
        .MAX_VARIABLE_ID(MAXV), .VARIABLE_ENCODING_LEN(ENC), .MAX_CLAUSE(NC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .host_if(host_if),
        .update_assignment_o(upd), .decision_variable_id_o(bid), .decision_assignment_o(bval),
        .clause_unit_i(cu), .clause_conflict_i(cc),
        .implication_variable_id_i(iid), .implication_assignment_i(ia),
        .assigned_o(asg), .assignment_value_o(aval)
    );

    // Clause table: up to three literals per clause, var 0 = unused literal.
    int  cl_var [NC][3];
    bit  cl_pos [NC][3];
    bit  stub_mode;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Clause status under a partial assignment: 0 none, 1 conflict, 2+2v+p unit implying v=p.
    function automatic int clause_code(input int k, input logic [MAXV:0] kn, input logic [MAXV:0] vl);
        int nl, nun, uv, up;
        bit sat;
        if (stub_mode) return (k == 0) ? 2 : 0;
        nl = 0; nun = 0; uv = 0; up = 0; sat = 0;
        for (int j = 0; j < 3; j++) begin
            if (cl_var[k][j] != 0) begin
                nl++;
                if (kn[cl_var[k][j]]) begin
                    if (vl[cl_var[k][j]] == cl_pos[k][j]) sat = 1;
                end else begin
                    nun++; uv = cl_var[k][j]; up = int'(cl_pos[k][j]);
                end
            end
        end
        if (nl == 0 || sat) return 0;
        if (nun == 0) return 1;
        if (nun == 1) return 2 + uv * 2 + up;
        return 0;
    endfunction

    // Clause-array registers: follow the broadcast strobe, reset with the controller.
    logic [MAXV:0] env_kn, env_vl;
    always @(posedge clk) begin
        if (rst) begin
            env_kn <= '0; env_vl <= '0;
        end else if (upd && bid != 0 && int'(bid) <= MAXV) begin
            env_kn[bid] <= 1'b1; env_vl[bid] <= bval;
        end
    end

    // Clause flags, refreshed mid-cycle from the clause registers.
    always @(negedge clk) begin
        for (int k = 0; k < NC; k++) begin
            int c;
            c = clause_code(k, env_kn, env_vl);
            cu[k] <= (c >= 2);
            cc[k] <= (c == 1);
            iid[k*ENC +: ENC] <= (c >= 2) ? ENC'((c - 2) / 2) : '0;
            ia[k] <= (c >= 2) ? ((c - 2) % 2 == 1) : 1'b0;
        end
    end

    // Reference model state and expectations.
    logic [MAXV:0] m_kn, m_vl;
    int exp_st, exp_cnt, exp_lat;
    int exp_q[$];
    int obs_q[$];
    int obs_st, obs_cnt, obs_lat;

    task automatic model_run(input int id, input int val);
        int cyc, c, sel, v, p;
        bit conf;
        exp_q.delete(); exp_cnt = 0;
        if (id == 0 || id > MAXV || m_kn[id]) begin
            exp_st = ST_REJ; exp_lat = 1; return;
        end
        m_kn[id] = 1'b1; m_vl[id] = val[0];
        cyc = 1; exp_q.push_back(cyc * 64 + id * 2 + val);
        for (int g = 0; g < 32; g++) begin
            sel = -1; conf = 0;
            for (int k = 0; k < NC; k++) begin
                c = clause_code(k, m_kn, m_vl);
                if (c == 1) conf = 1;
                else if (c >= 2 && sel < 0) sel = c;
            end
            exp_lat = cyc + 2;
            if (conf) begin exp_st = ST_CONF; return; end
            if (sel < 0) begin exp_st = ST_OK; return; end
            v = (sel - 2) / 2; p = (sel - 2) % 2;
            if (v == 0 || m_kn[v]) begin exp_st = ST_PROTO; return; end
            m_kn[v] = 1'b1; m_vl[v] = p[0];
            if (exp_cnt < 7) exp_cnt++;
            cyc += 2;
            exp_q.push_back(cyc * 64 + v * 2 + p);
        end
    endtask

    task automatic set_clear();
        stub_mode = 0;
        for (int k = 0; k < NC; k++)
            for (int j = 0; j < 3; j++) begin cl_var[k][j] = 0; cl_pos[k][j] = 0; end
    endtask

    task automatic set_clause(input int k, input int v0, input bit p0, input int v1, input bit p1);
        cl_var[k][0] = v0; cl_pos[k][0] = p0;
        cl_var[k][1] = v1; cl_pos[k][1] = p1;
        cl_var[k][2] = 0;  cl_pos[k][2] = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        m_kn = '0; m_vl = '0;
        @(negedge clk);
    endtask

    task automatic do_decision(input int id, input int val, input int delay, input bit hold_valid);
        int k, waited;
        bit got;
        waited = 0;
        while (!host_if.decision_ready_o && waited < 20) begin @(negedge clk); waited++; end
        chk("rdy_wait", host_if.decision_ready_o, 1);
        model_run(id, val);
        host_if.decision_valid_i       = 1'b1;
        host_if.decision_variable_id_i = ENC'(id);
        host_if.decision_assignment_i  = val[0];
        obs_q.delete(); got = 0; k = 0; obs_lat = 0;
        while (!got && k < 64) begin
            @(negedge clk); k++;
            if (k == 1) chk("busy_rdy", host_if.decision_ready_o, 0);
            if (hold_valid) begin
                host_if.decision_variable_id_i = ENC'($urandom_range(0, 7));
                host_if.decision_assignment_i  = 1'($urandom_range(0, 1));
            end else begin
                host_if.decision_valid_i = 1'b0;
            end
            if (upd) obs_q.push_back(k * 64 + int'(bid) * 2 + int'(bval));
            else chk("bus_idle", {bid, bval}, 0);
            if (host_if.result_valid_o) begin got = 1; obs_lat = k; end
        end
        obs_st  = int'(host_if.result_status_o);
        obs_cnt = int'(host_if.result_implication_count_o);
        if (!got) begin
            chk("timeout", 0, 1);
        end else begin
            chk("latency", obs_lat, exp_lat);
            chk("status", obs_st, exp_st);
            chk("count", obs_cnt, exp_cnt);
            chk("n_strobes", obs_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk("strobe", obs_q[i], exp_q[i]);
            chk("assigned", asg, m_kn);
            chk("values", aval & asg, m_vl & m_kn);
        end
        repeat (delay) begin
            @(negedge clk);
            chk("hold", {host_if.result_valid_o, host_if.result_status_o, host_if.result_implication_count_o, upd},
                {1'b1, 2'(exp_st), 3'(exp_cnt), 1'b0});
        end
        host_if.result_ready_i   = 1'b1;
        host_if.decision_valid_i = 1'b0;
        @(negedge clk);
        chk("release", {host_if.decision_ready_o, host_if.result_valid_o}, 2'b10);
        host_if.result_ready_i = 1'b0;
    endtask

    initial begin
        int perm[4];
        int tmp, j, nclauses;
        rst = 1'b1;
        host_if.decision_valid_i = 1'b0;
        host_if.decision_variable_id_i = '0;
        host_if.decision_assignment_i = 1'b0;
        host_if.result_ready_i = 1'b0;
        m_kn = '0; m_vl = '0;
        set_clear();

        // Reset with a decision pending: nothing accepted, every output zero.
        @(negedge clk);
        host_if.decision_valid_i = 1'b1; host_if.decision_variable_id_i = 3'd3; host_if.decision_assignment_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out", {host_if.decision_ready_o, host_if.result_valid_o, host_if.result_status_o,
                            host_if.result_implication_count_o, upd, bid, bval, asg, aval}, 0);
        end
        rst = 1'b0; host_if.decision_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_rdy", host_if.decision_ready_o, 1);
        @(negedge clk);
        chk("rst_noacc", {upd, asg, host_if.result_valid_o}, 0);

        // Empty clause array: x3=1 propagates nothing.
        do_decision(3, 1, 0, 0);
        chk("single_lat", obs_lat, 3);
        chk("single_asg", asg, 5'b01000);

        // Chain (~x1|x2), (~x2|x3) with held-off result acceptance.
        do_reset(1);
        set_clause(0, 1, 0, 2, 1);
        set_clause(1, 2, 0, 3, 1);
        do_decision(1, 1, 5, 0);
        chk("chain_cnt", obs_cnt, 2);
        chk("chain_lat", obs_lat, 7);
        chk("chain_asg", asg, 5'b01110);

        // Rejections: id 0, then an already-assigned id.
        do_decision(0, 1, 0, 0);
        chk("rej0_st", obs_st, ST_REJ);
        do_decision(1, 0, 1, 0);
        chk("rej1_st", obs_st, ST_REJ);
        chk("rej_asg", asg, 5'b01110);

        // Conflict: (~x1|x2) at 0 wins over (~x1|~x2) at 1, then clause 1 fails.
        do_reset(1);
        set_clear();
        set_clause(0, 1, 0, 2, 1);
        set_clause(1, 1, 0, 2, 0);
        do_decision(1, 1, 0, 0);
        chk("conf_st", obs_st, ST_CONF);
        chk("conf_cnt", obs_cnt, 1);
        chk("conf_lat", obs_lat, 5);

        // A clause claiming unit on id 0 is a protocol error.
        do_reset(1);
        set_clear();
        stub_mode = 1;
        do_decision(2, 0, 0, 0);
        chk("proto_st", obs_st, ST_PROTO);
        stub_mode = 0;

        // Reset in the middle of the chain.
        do_reset(1);
        set_clause(0, 1, 0, 2, 1);
        set_clause(1, 2, 0, 3, 1);
        host_if.decision_valid_i = 1'b1; host_if.decision_variable_id_i = 3'd1; host_if.decision_assignment_i = 1'b1;
        @(negedge clk); host_if.decision_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_strobe", {upd, bid, bval}, {1'b1, 3'd2, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        chk("mr_zero", {host_if.decision_ready_o, host_if.result_valid_o, upd, bid, asg, aval}, 0);
        rst = 1'b0; m_kn = '0; m_vl = '0;
        repeat (4) begin
            @(negedge clk);
            chk("mr_quiet", {upd, asg, host_if.result_valid_o}, 0);
        end
        chk("mr_rdy", host_if.decision_ready_o, 1);

        // Random clause sets and decisions, decision inputs sometimes toggling while busy.
        for (int it = 0; it < 48; it++) begin
            if (it % 8 == 0) begin
                do_reset(1);
                set_clear();
                nclauses = $urandom_range(1, NC);
                for (int k = 0; k < nclauses; k++) begin
                    perm = '{1, 2, 3, 4};
                    for (int i = 3; i > 0; i--) begin
                        j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
                    end
                    for (int l = 0; l < 3; l++) begin
                        cl_var[k][l] = (l < 2 || $urandom_range(0, 1) == 1) ? perm[l] : 0;
                        cl_pos[k][l] = 1'($urandom_range(0, 1));
                    end
                end
            end
            do_decision($urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
